uart_rx_loader: RTL and testbench

UART_RX_LOADER -- requirements
Module: uart_rx_loader

---
 rtl/uart_rx_loader.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_loader.sv
// rtl/uart_rx_loader.sv - AXI4-Lite UART polling loader that packs received byte pairs into memory words
module uart_rx_loader #(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int MEMORY_ADDR_WIDTH  = 18,
    parameter int MEMORY_DATA_WIDTH  = 16,
    parameter int LOAD_WORDS         = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            UART_initialize,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,

    output logic [MEMORY_ADDR_WIDTH-1:0]    mem_addr,
    output logic [MEMORY_DATA_WIDTH-1:0]    mem_wdata,
    output logic                            mem_we,

    output logic                            busy,
    output logic                            done,
    output logic                            error
);

    typedef enum logic [3:0] {
        IDLE,
        CFG_W,
        CFG_B,
        POLL_AR,
        POLL_R,
        RX_AR,
        RX_R,
        MEM_WR,
        DONE,
        ERROR
    } state_t;

    // UART-lite register map: RX FIFO at 0x0, status at 0x8, control at 0xC
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_RX   = C_M_AXI_ADDR_WIDTH'(0);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_STAT = C_M_AXI_ADDR_WIDTH'(8);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_CTRL = C_M_AXI_ADDR_WIDTH'(12);
    localparam logic [C_M_AXI_DATA_WIDTH-1:0] CTRL_RST_FIFOS = C_M_AXI_DATA_WIDTH'(3);
    localparam logic [MEMORY_ADDR_WIDTH:0]    LOAD_CNT = (MEMORY_ADDR_WIDTH+1)'(LOAD_WORDS);

    state_t                         state_q, state_d;
    logic                           aw_done_q, aw_done_d;
    logic                           w_done_q, w_done_d;
    logic                           phase_q, phase_d;
    logic [MEMORY_ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [MEMORY_DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MEMORY_ADDR_WIDTH:0]     word_cnt_q, word_cnt_d;
    logic [MEMORY_ADDR_WIDTH:0]     word_cnt_inc;

    logic unused_rdata;
    assign unused_rdata = ^M_AXI_RDATA[C_M_AXI_DATA_WIDTH-1:8];

    assign word_cnt_inc = word_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        phase_d     = phase_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        word_cnt_d  = word_cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (UART_initialize) begin
                    state_d    = CFG_W;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    phase_d    = 1'b0;
                    mem_addr_d = '0;
                    word_cnt_d = '0;
                end
            end
            CFG_W: begin
                // AW and W complete independently; leave once both have been accepted
                if (M_AXI_AWREADY) begin
                    aw_done_d = 1'b1;
                end
                if (M_AXI_WREADY) begin
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || M_AXI_AWREADY) && (w_done_q || M_AXI_WREADY)) begin
                    state_d = CFG_B;
                end
            end
            CFG_B: begin
                if (M_AXI_BVALID) begin
                    state_d = (M_AXI_BRESP == 2'b00) ? POLL_AR : ERROR;
                end
            end
            POLL_AR: begin
                if (M_AXI_ARREADY) begin
                    state_d = POLL_R;
                end
            end
            POLL_R: begin
                if (M_AXI_RVALID) begin
                    if (M_AXI_RRESP != 2'b00) begin
                        state_d = ERROR;
                    end else if (M_AXI_RDATA[0]) begin
                        state_d = RX_AR;
                    end else begin
                        state_d = POLL_AR;
                    end
                end
            end
            RX_AR: begin
                if (M_AXI_ARREADY) begin
                    state_d = RX_R;
                end
            end
            RX_R: begin
                if (M_AXI_RVALID) begin
                    if (M_AXI_RRESP != 2'b00) begin
                        state_d = ERROR;
                    end else if (!phase_q) begin
                        mem_wdata_d[MEMORY_DATA_WIDTH-1 -: 8] = M_AXI_RDATA[7:0];
                        phase_d = 1'b1;
                        state_d = POLL_AR;
                    end else begin
                        mem_wdata_d[7:0] = M_AXI_RDATA[7:0];
                        phase_d = 1'b0;
                        state_d = MEM_WR;
                    end
                end
            end
            MEM_WR: begin
                mem_addr_d = mem_addr_q + 1'b1;
                word_cnt_d = word_cnt_inc;
                state_d    = (word_cnt_inc == LOAD_CNT) ? DONE : POLL_AR;
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            phase_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            phase_q     <= phase_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    // Bus outputs decode straight from state so they hold steady until accepted
    assign M_AXI_AWADDR  = (state_q == CFG_W) ? ADDR_CTRL : '0;
    assign M_AXI_AWVALID = (state_q == CFG_W) && !aw_done_q;
    assign M_AXI_WDATA   = (state_q == CFG_W) ? CTRL_RST_FIFOS : '0;
    assign M_AXI_WSTRB   = (state_q == CFG_W) ? '1 : '0;
    assign M_AXI_WVALID  = (state_q == CFG_W) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == CFG_B);
    assign M_AXI_ARADDR  = (state_q == POLL_AR) ? ADDR_STAT : ADDR_RX;
    assign M_AXI_ARVALID = (state_q == POLL_AR) || (state_q == RX_AR);
    assign M_AXI_RREADY  = (state_q == POLL_R) || (state_q == RX_R);

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = (state_q == MEM_WR);

    assign busy  = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
    assign done  = (state_q == DONE);
    assign error = (state_q == ERROR);

endmodule

// File: tb/tb_uart_rx_loader.sv
// tb/tb_uart_rx_loader.sv - self-checking bench for uart_rx_loader with a reactive UART-lite slave
module tb_uart_rx_loader;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int MAW = 2;
    localparam int MDW = 16;
    localparam int LW  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              UART_initialize;
    logic [AW-1:0]     awaddr;
    logic              awvalid, awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wvalid, wready;
    logic [1:0]        bresp;
    logic              bvalid, bready;
    logic [AW-1:0]     araddr;
    logic              arvalid, arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid, rready;
    logic [MAW-1:0]    mem_addr;
    logic [MDW-1:0]    mem_wdata;
    logic              mem_we;
    logic              busy, done, error;

    always #5 clk = ~clk;

    uart_rx_loader #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .MEMORY_ADDR_WIDTH(MAW),
        .MEMORY_DATA_WIDTH(MDW),
        .LOAD_WORDS(LW)
    ) dut (
        .clk(clk), .reset(reset), .UART_initialize(UART_initialize),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .busy(busy), .done(done), .error(error)
    );

    // slave knobs and observation queues
    int   ready_max, poll_zero_max, err_poll, zeros_left, poll_idx;
    logic [1:0] bresp_val;
    bit   fixed_mode, ar_hold, r_hold;
    int   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit   r_pend;
    logic [AW-1:0] r_addr;
    logic [7:0]    rx_q[$];
    logic [7:0]    exp_bytes[8];
    logic [AW-1:0] aw_q[$];
    logic [AW-1:0] ar_q[$];
    logic [35:0]   w_q[$];
    logic [MAW+MDW-1:0] wr_q[$];

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int         ready_max;
        int         zero_max;
        int         err_poll;
        logic [1:0] bresp;
        logic       exp_done;
        logic       exp_error;
        int         exp_writes;
    } row_t;
    row_t rows[6];

    function automatic int pick(input int ch);
        if (fixed_mode) return (ch == 1) ? 1 : 0;
        return int'($urandom_range(0, ready_max));
    endfunction

    // Slave reacts on the falling edge; anything it raises is sampled by the DUT at the next rising edge
    initial begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        aw_cnt = -1; w_cnt = -1; b_cnt = -1; ar_cnt = -1; r_cnt = -1; r_pend = 0; r_addr = '0;
        forever begin
            @(negedge clk);
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            bresp = 0; rresp = 0; rdata = 0;
            if (reset) begin
                aw_cnt = -1; w_cnt = -1; b_cnt = -1; ar_cnt = -1; r_cnt = -1; r_pend = 0;
            end else begin
                if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
                if (awvalid) begin
                    if (aw_cnt < 0) aw_cnt = pick(0);
                    if (aw_cnt == 0) begin awready = 1; aw_cnt = -1; aw_q.push_back(awaddr); end
                    else aw_cnt--;
                end
                if (wvalid) begin
                    if (w_cnt < 0) w_cnt = pick(1);
                    if (w_cnt == 0) begin wready = 1; w_cnt = -1; w_q.push_back({wstrb, wdata}); end
                    else w_cnt--;
                end
                if (bready) begin
                    if (b_cnt < 0) b_cnt = pick(0);
                    if (b_cnt == 0) begin bvalid = 1; bresp = bresp_val; b_cnt = -1; end
                    else b_cnt--;
                end
                if (arvalid && !ar_hold) begin
                    if (ar_cnt < 0) ar_cnt = pick(0);
                    if (ar_cnt == 0) begin
                        arready = 1; ar_cnt = -1; r_pend = 1; r_addr = araddr; ar_q.push_back(araddr);
                    end else ar_cnt--;
                end else if (rready && r_pend && !r_hold) begin
                    if (r_cnt < 0) r_cnt = pick(0);
                    if (r_cnt == 0) begin
                        rvalid = 1; r_cnt = -1; r_pend = 0;
                        if (r_addr == AW'(8)) begin
                            if (poll_idx == err_poll) rresp = 2'b10;
                            else if (zeros_left > 0) begin
                                rdata = $urandom & 32'hFFFF_FFFE;
                                zeros_left--;
                            end else begin
                                rdata = $urandom | 32'h1;
                                zeros_left = int'($urandom_range(0, poll_zero_max));
                            end
                            poll_idx++;
                        end else begin
                            rdata = $urandom & 32'hFFFF_FF00;
                            if (rx_q.size() > 0) rdata[7:0] = rx_q.pop_front();
                        end
                    end else r_cnt--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        reset = 1; UART_initialize = 0;
        tick(); tick();
        reset = 0;
    endtask

    task automatic pulse_init();
        UART_initialize = 1;
        tick();
        UART_initialize = 0;
    endtask

    task automatic session_setup(input int rmax, input int zmax, input int ep, input logic [1:0] br);
        ready_max = rmax; poll_zero_max = zmax; err_poll = ep; bresp_val = br;
        aw_q.delete(); w_q.delete(); ar_q.delete(); wr_q.delete(); rx_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_bytes[i] = 8'($urandom);
            rx_q.push_back(exp_bytes[i]);
        end
        poll_idx = 0;
        zeros_left = int'($urandom_range(0, zmax));
    endtask

    task automatic wait_end(input string name, input int budget);
        int n = 0;
        while (!(done || error) && n < budget) begin tick(); n++; end
        if (!(done || error)) begin
            n_total++;
            $display("FAIL %s: timeout, got no done/error expected one within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_sig(input string name, input int sel, input int budget);
        int n = 0;
        while (!((sel == 0) ? arvalid : rready) && n < budget) begin tick(); n++; end
        if (!((sel == 0) ? arvalid : rready)) begin
            n_total++;
            $display("FAIL %s: timeout, got signal low expected high within %0d cycles", name, budget);
        end
    endtask

    // Reference: word k is {byte 2k, byte 2k+1} stored at k modulo the memory depth
    task automatic check_writes(input string name, input int n);
        logic [MAW+MDW-1:0] e;
        check({name, "_wr_count"}, wr_q.size(), n);
        for (int k = 0; k < n && k < wr_q.size(); k++) begin
            e = {MAW'(k % (1 << MAW)), exp_bytes[2*k], exp_bytes[2*k+1]};
            check($sformatf("%s_wr%0d", name, k), wr_q[k], e);
        end
    endtask

    task automatic check_cfg(input string name);
        check({name, "_aw_count"}, aw_q.size(), 1);
        if (aw_q.size() > 0) check({name, "_aw_addr"}, aw_q[0], 4'hC);
        if (w_q.size() > 0) check({name, "_w_data"}, w_q[0], {4'hF, 32'h3});
    endtask

    initial begin
        rows[0] = '{0, 0, -1, 2'b00, 1'b1, 1'b0, 4};
        rows[1] = '{3, 2, -1, 2'b00, 1'b1, 1'b0, 4};
        rows[2] = '{5, 3, -1, 2'b00, 1'b1, 1'b0, 4};
        rows[3] = '{2, 1,  1, 2'b00, 1'b0, 1'b1, 0};
        rows[4] = '{1, 0, -1, 2'b10, 1'b0, 1'b1, 0};
        rows[5] = '{0, 0,  7, 2'b00, 1'b0, 1'b1, 3};
        ready_max = 0; poll_zero_max = 0; err_poll = -1; bresp_val = 0;
        fixed_mode = 0; ar_hold = 0; r_hold = 0; zeros_left = 0; poll_idx = 0;

        do_reset();
        check("rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, mem_we, busy, done, error}, 0);
        check("rst_bus", {awaddr, araddr, wdata, wstrb}, 0);
        check("rst_mem", {mem_addr, mem_wdata}, 0);

        // config timing: AWREADY one cycle ahead of WREADY
        session_setup(0, 2, -1, 2'b00);
        fixed_mode = 1;
        pulse_init();
        check("cfg_c0_valids", {awvalid, wvalid, busy}, 3'b111);
        check("cfg_c0_payload", {awaddr, wdata, wstrb}, {4'hC, 32'h3, 4'hF});
        tick();
        check("cfg_c1_valids", {awvalid, wvalid}, 2'b01);
        tick();
        check("cfg_c2", {awvalid, wvalid, bready}, 3'b001);
        tick();
        check("cfg_c3_ar", {arvalid, araddr, bready}, {1'b1, 4'h8, 1'b0});
        wait_end("cfg", 4000);
        fixed_mode = 0;
        check("cfg_status", {busy, done, error}, 3'b010);
        check("cfg_wrap_addr", mem_addr, 0);
        check_writes("cfg", LW);
        check_cfg("cfg");
        if (ar_q.size() > 0) check("cfg_first_ar", ar_q[0], 4'h8);

        for (int r = 0; r < 6; r++) begin
            do_reset();
            session_setup(rows[r].ready_max, rows[r].zero_max, rows[r].err_poll, rows[r].bresp);
            pulse_init();
            wait_end($sformatf("row%0d", r), 4000);
            check($sformatf("row%0d_status", r), {busy, done, error}, {1'b0, rows[r].exp_done, rows[r].exp_error});
            check_writes($sformatf("row%0d", r), rows[r].exp_writes);
            check_cfg($sformatf("row%0d", r));
            if (rows[r].exp_done) check($sformatf("row%0d_wrap_addr", r), mem_addr, 0);
            if (rows[r].exp_error) check($sformatf("row%0d_err_outs", r), {awvalid, wvalid, bready, arvalid, rready, mem_we}, 0);
        end

        // error is terminal: a new start pulse is ignored until reset
        do_reset();
        session_setup(1, 1, 1, 2'b00);
        pulse_init();
        wait_end("err", 4000);
        check("err_status", {busy, done, error}, 3'b001);
        check_writes("err", 0);
        pulse_init();
        tick();
        check("err_ignores_init", {error, busy, awvalid}, 3'b100);
        do_reset();
        check("err_cleared", {busy, done, error}, 3'b000);

        // reset while a read address is waiting for ARREADY
        session_setup(2, 1, -1, 2'b00);
        ar_hold = 1;
        pulse_init();
        wait_sig("rmid_ar", 0, 200);
        check("rmid_before", {arvalid, araddr}, {1'b1, 4'h8});
        reset = 1;
        tick();
        check("rmid_after", {arvalid, rready, awvalid, busy, done, error}, 0);
        reset = 0;
        ar_hold = 0;
        session_setup(2, 1, -1, 2'b00);
        pulse_init();
        check("rmid_restart", {awvalid, wvalid, mem_addr}, {1'b1, 1'b1, 2'b00});
        wait_end("rmid", 4000);
        check("rmid_status", {busy, done, error}, 3'b010);
        check_writes("rmid", LW);

        // restart from DONE, and a start pulse during POLL_R is ignored
        session_setup(1, 1, -1, 2'b00);
        r_hold = 1;
        pulse_init();
        check("rst_from_done", {done, busy, awvalid, mem_addr}, {1'b0, 1'b1, 1'b1, 2'b00});
        wait_sig("poll_r", 1, 200);
        pulse_init();
        check("poll_r_ignores_init", {awvalid, rready, busy}, 3'b011);
        r_hold = 0;
        wait_end("restart", 4000);
        check("restart_status", {busy, done, error}, 3'b010);
        check_writes("restart", LW);
        check_cfg("restart");

        do_reset();
        check("final_rst", {mem_addr, mem_wdata, busy, done, error}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
